// File: rtl/twobit_pkg.sv
// Shared types for the two-bit cascade magnitude comparator.
package twobit_pkg;
   localparam int W = 2;

   typedef logic [1:0] cmp_t;

   localparam cmp_t LT = 2'b00;
   localparam cmp_t GT = 2'b01;
   localparam cmp_t EQ = 2'b10;

   function automatic logic is_lt(input cmp_t r);
      return r == LT;
   endfunction
endpackage

// File: rtl/twobit_cell.sv
// One-bit cascade compare cell: upstream {eq,gt} plus one bit of a and b.
module twobit_cell
   import twobit_pkg::*;
(
   input  logic eqIn,
   input  logic gtIn,
   input  logic a,
   input  logic b,
   output logic eqOut,
   output logic gtOut
);

   cmp_t r;

   always_comb begin
      r = LT;
      unique case (1'b1)
         eqIn & a & ~b:    r = GT;
         eqIn & (a == b):  r = EQ;
         ~eqIn & gtIn:     r = GT;
         default:          r = LT;
      endcase
   end

   assign eqOut = r[1];
   assign gtOut = r[0];

endmodule

// File: rtl/twobit.sv
// Two-bit cascadable unsigned comparator with optional output register.
// Define TWOBIT_LT_OUT_EN to add the ltOut port.
module twobit
   import twobit_pkg::*;
#(
   parameter int OUT_REG = 1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         inValid,
   input  logic         eqIn,
   input  logic         gtIn,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eqOut,
   output logic         gtOut,
   output logic         outValid
`ifdef TWOBIT_LT_OUT_EN
   ,
   output logic         ltOut
`endif
);

   logic hi_eq;
   logic hi_gt;
   logic lo_eq;
   logic lo_gt;
   cmp_t res;

   twobit_cell u_hi (
      .eqIn  (eqIn),
      .gtIn  (gtIn),
      .a     (a[1]),
      .b     (b[1]),
      .eqOut (hi_eq),
      .gtOut (hi_gt)
   );

   twobit_cell u_lo (
      .eqIn  (hi_eq),
      .gtIn  (hi_gt),
      .a     (a[0]),
      .b     (b[0]),
      .eqOut (lo_eq),
      .gtOut (lo_gt)
   );

   assign res = {lo_eq, lo_gt};

   generate
      if (OUT_REG != 0) begin : g_reg
         cmp_t res_q;
         logic vld_q;

         // Result loads every cycle; vld_q alone says whether it counts.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               res_q <= LT;
               vld_q <= 1'b0;
            end else begin
               res_q <= res;
               vld_q <= inValid;
            end
         end

         assign eqOut    = res_q[1];
         assign gtOut    = res_q[0];
         assign outValid = vld_q;

`ifdef TWOBIT_LT_OUT_EN
         logic lt_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) lt_q <= 1'b0;
            else     lt_q <= is_lt(res);
         end

         assign ltOut = lt_q;
`endif
      end else begin : g_comb
         assign eqOut    = res[1];
         assign gtOut    = res[0];
         assign outValid = inValid & ~rst;
`ifdef TWOBIT_LT_OUT_EN
         assign ltOut    = is_lt(res);
`endif
      end
   endgenerate

endmodule

// File: tb/tb_twobit.sv
// Directed vector bench for twobit: registered sweep, reset, and chained compare.
module tb_twobit;

   typedef struct {
      logic       eq_in;
      logic       gt_in;
      logic [1:0] a;
      logic [1:0] b;
      logic       eq_exp;
      logic       gt_exp;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       eq_in;
   logic       gt_in;
   logic [1:0] a;
   logic [1:0] b;
   logic       eq_out;
   logic       gt_out;
   logic       out_valid;
`ifdef TWOBIT_LT_OUT_EN
   logic       lt_out;
   logic       c_lt_hi;
   logic       c_lt_lo;
`endif

   logic       c_rst;
   logic       c_vld;
   logic [1:0] c_a_hi;
   logic [1:0] c_b_hi;
   logic [1:0] c_a_lo;
   logic [1:0] c_b_lo;
   logic       c_eq_hi;
   logic       c_gt_hi;
   logic       c_eq_lo;
   logic       c_gt_lo;
   logic       c_v_hi;
   logic       c_v_lo;

   int total;
   int bad;

   vec_t vecs[$];

   twobit #(.OUT_REG(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (in_valid),
      .eqIn     (eq_in),
      .gtIn     (gt_in),
      .a        (a),
      .b        (b),
      .eqOut    (eq_out),
      .gtOut    (gt_out),
      .outValid (out_valid)
`ifdef TWOBIT_LT_OUT_EN
      ,
      .ltOut    (lt_out)
`endif
   );

   // Combinational pair chained into an 8-bit-wide... really 4-bit compare.
   twobit #(.OUT_REG(0)) u_hi (
      .clk      (clk),
      .rst      (c_rst),
      .inValid  (c_vld),
      .eqIn     (1'b1),
      .gtIn     (1'b0),
      .a        (c_a_hi),
      .b        (c_b_hi),
      .eqOut    (c_eq_hi),
      .gtOut    (c_gt_hi),
      .outValid (c_v_hi)
`ifdef TWOBIT_LT_OUT_EN
      ,
      .ltOut    (c_lt_hi)
`endif
   );

   twobit #(.OUT_REG(0)) u_lo (
      .clk      (clk),
      .rst      (c_rst),
      .inValid  (c_v_hi),
      .eqIn     (c_eq_hi),
      .gtIn     (c_gt_hi),
      .a        (c_a_lo),
      .b        (c_b_lo),
      .eqOut    (c_eq_lo),
      .gtOut    (c_gt_lo),
      .outValid (c_v_lo)
`ifdef TWOBIT_LT_OUT_EN
      ,
      .ltOut    (c_lt_lo)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2:0] act,
                      input logic [2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {v,eq,gt}=%b want %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic g,
                               input logic [1:0] av, input logic [1:0] bv);
      vec_t v;
      int ai;
      int bi;
      ai = int'(av);
      bi = int'(bv);
      v.eq_in = e;
      v.gt_in = g;
      v.a = av;
      v.b = bv;
      if (e) begin
         v.eq_exp = (ai == bi);
         v.gt_exp = (ai > bi);
      end else begin
         v.eq_exp = 1'b0;
         v.gt_exp = g;
      end
      return v;
   endfunction

   task automatic drive(input vec_t v, input logic vld);
      in_valid = vld;
      eq_in = v.eq_in;
      gt_in = v.gt_in;
      a = v.a;
      b = v.b;
   endtask

   initial begin
      vec_t v;
      total = 0;
      bad = 0;
      rst = 1'b1;
      c_rst = 1'b0;
      c_vld = 1'b0;
      c_a_hi = 2'd0;
      c_b_hi = 2'd0;
      c_a_lo = 2'd0;
      c_b_lo = 2'd0;
      in_valid = 1'b0;
      eq_in = 1'b0;
      gt_in = 1'b0;
      a = 2'd0;
      b = 2'd0;

      for (int i = 0; i < 64; i++) begin
         logic [5:0] k;
         k = 6'(i);
         vecs.push_back(mk(k[5], k[4], k[3:2], k[1:0]));
      end
      // Hand-picked cases with hand-computed results.
      vecs.push_back('{1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0});

      #12;
      chk("reset_state", {out_valid, eq_out, gt_out}, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i], 1'b1);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), {out_valid, eq_out, gt_out},
             {1'b1, vecs[i].eq_exp, vecs[i].gt_exp});
      end

      // Async reset while an EQ result is valid.
      @(negedge clk);
      drive(mk(1'b1, 1'b0, 2'd3, 2'd3), 1'b1);
      @(posedge clk);
      #1;
      chk("pre_rst_eq", {out_valid, eq_out, gt_out}, 3'b110);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", {out_valid, eq_out, gt_out}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("no_pulse_after_rst", {out_valid, 2'b00}, 3'b000);

      // First accepted input after reset appears one cycle later.
      @(negedge clk);
      drive(mk(1'b1, 1'b0, 2'd2, 2'd0), 1'b1);
      #1;
      chk("not_yet_valid", {out_valid, 2'b00}, 3'b000);
      @(posedge clk);
      #1;
      chk("first_after_rst", {out_valid, eq_out, gt_out}, 3'b101);

      // Valid dropped: flag must follow one cycle later.
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("valid_drop", {out_valid, 2'b00}, 3'b000);

`ifdef TWOBIT_LT_OUT_EN
      @(negedge clk);
      drive(mk(1'b1, 1'b0, 2'd0, 2'd1), 1'b1);
      @(posedge clk);
      #1;
      chk("lt_out", {lt_out, eq_out, gt_out}, 3'b100);
`endif

      // 4-bit chain: 0xB vs 0x9, then 0x9 vs 0x9, then 0x6 vs 0x9.
      c_vld = 1'b1;
      c_a_hi = 2'b10;
      c_b_hi = 2'b10;
      c_a_lo = 2'b11;
      c_b_lo = 2'b01;
      #1;
      chk("chain_b_gt_9", {c_v_lo, c_eq_lo, c_gt_lo}, 3'b101);
      c_a_lo = 2'b01;
      #1;
      chk("chain_9_eq_9", {c_v_lo, c_eq_lo, c_gt_lo}, 3'b110);
      c_a_hi = 2'b01;
      c_a_lo = 2'b10;
      #1;
      chk("chain_6_lt_9", {c_v_lo, c_eq_lo, c_gt_lo}, 3'b100);
      c_vld = 1'b0;
      #1;
      chk("chain_valid_off", {c_v_lo, 2'b00}, 3'b000);
      c_vld = 1'b1;
      c_rst = 1'b1;
      #1;
      chk("chain_rst_valid", {c_v_lo, 2'b00}, 3'b000);
      c_rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/twobit.md
TWOBIT -- requirements
Module: twobit

Interface
REQ-001 Parameter OUT_REG, default 1: 1 registers the outputs (one-cycle latency); 0 makes the outputs combinational from the inputs, and the clock and reset are then used only by the valid flag.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inValid  input  1  qualifies eqIn, gtIn, a and b in the current cycle.
REQ-005 eqIn  input  1  cascade "equal so far" from the more-significant stage.
REQ-006 gtIn  input  1  cascade "greater so far" from the more-significant stage.
REQ-007 a  input  2  operand A, unsigned, a[1] is the MSB.
REQ-008 b  input  2  operand B, unsigned, b[1] is the MSB.
REQ-009 eqOut  output  1  cascade result: A equals B, including all upstream bits.
REQ-010 gtOut  output  1  cascade result: A is greater than B, including all upstream bits.
REQ-011 outValid  output  1  qualifies eqOut and gtOut.
REQ-012 Port order: clk, rst, inValid, eqIn, gtIn, a, b, eqOut, gtOut, outValid, then any optional ports.

Function
REQ-013 eqIn=1: the result SHALL depend only on a and b (gtIn is ignored):
- a>b -> eqOut=0, gtOut=1
- a==b -> eqOut=1, gtOut=0
- a<b -> eqOut=0, gtOut=0
REQ-014 eqIn=0, gtIn=1: result SHALL be eqOut=0, gtOut=1, regardless of a and b.
REQ-015 eqIn=0, gtIn=0: result SHALL be eqOut=0, gtOut=0, regardless of a and b.
REQ-016 eqOut and gtOut SHALL never both be 1.
REQ-017 The comparison is unsigned over the two bits: bit 1 decides first, and bit 0 decides only when a[1]==b[1].
REQ-018 OUT_REG=1:
- outputs update on the clk rising edge after the inputs are sampled (latency 1 cycle);
- outValid is inValid delayed by 1 cycle;
- the result registers load every cycle, and their values are meaningful only when outValid=1.
REQ-019 OUT_REG=0: eqOut and gtOut SHALL follow the inputs combinationally in the same cycle, and outValid SHALL equal inValid.
REQ-020 Back-to-back inputs SHALL be accepted every cycle, with no stall and no backpressure.
REQ-021 Chaining gtOut/eqOut of one stage into gtIn/eqIn of the next SHALL give a correct wider comparison; the most-significant stage is tied to eqIn=1, gtIn=0.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force eqOut=0, gtOut=0, outValid=0, plus ltOut=0 when that port is present.
REQ-023 Release of rst SHALL take effect at the next clk edge, and the first valid result SHALL appear 1 cycle after the first accepted inValid.
REQ-024 Asserting rst mid-stream SHALL discard the in-flight result, with no outValid pulse for it.

Configuration
REQ-025 Macro TWOBIT_LT_OUT_EN:
- Defined: adds output ltOut (1 bit, last port) equal to the inverse of (eqOut OR gtOut), with the same latency, reset value and qualification as eqOut and gtOut.
- Undefined: the port and its logic are absent.

Structure
REQ-026 Package twobit_pkg SHALL hold:
- the cascade result encoding {eq,gt}: LT=2'b00, GT=2'b01, EQ=2'b10;
- operand width constant W=2.
REQ-027 Sub-module twobit_cell SHALL implement the 1-bit cascade cell (eqIn, gtIn, a, b -> eqOut, gtOut) with the same rules as REQ-013 to REQ-015.
REQ-028 twobit SHALL instantiate two twobit_cell instances: the bit-1 cell fed by eqIn and gtIn, and the bit-0 cell fed by the bit-1 cell's outputs. The output register stage sits in twobit.

Verification
REQ-029 Sweep all 64 combinations of eqIn, gtIn, a, b (OUT_REG=1) -> each result matches REQ-013 to REQ-015 exactly 1 cycle later with outValid=1. Example: eqIn=1, gtIn=1, a=2, b=1 -> eqOut=0, gtOut=1.
REQ-030 eqIn=1, gtIn=0, a=3, b=3 -> eqOut=1, gtOut=0; then a=1, b=2 on the next cycle -> eqOut=0, gtOut=0, so back-to-back results are correct.
REQ-031 eqIn=0, gtIn=1, a=0, b=3 -> eqOut=0, gtOut=1, so upstream "greater" overrides the operands.
REQ-032 Assert rst asynchronously while outValid=1 with eqOut=1 -> eqOut, gtOut and outValid fall to 0 without waiting for a clk edge.
REQ-033 Chain two instances comparing 4-bit A=0xB against B=0x9 -> the final stage gives gtOut=1, eqOut=0.
REQ-034 With TWOBIT_LT_OUT_EN defined, eqIn=1, a=0, b=1 -> ltOut=1, eqOut=0, gtOut=0.
